// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use, branch, R15-write and multicycle multiply stalls.
// Define HAZARD_MUL_STALL_EN to build the multiply occupancy logic (MUL state, cnt).
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3E,
  input  logic       memtoRegE,
  input  logic       regWriteE,
  input  logic       branchTakenE,
  input  logic       pcWriteD,
  input  logic       mulStartE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       mulBusyE
);

`ifdef HAZARD_MUL_STALL_EN
  typedef enum logic [2:0] {
    IDLE, PCW_E, PCW_M, PCW_W, MUL
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, PCW_E, PCW_M, PCW_W
  } state_t;
`endif

  state_t state_q, state_d;

  logic ld_stall;
  logic pc_acc;

  logic s_f, s_d, s_e;
  logic f_d, f_e, f_m;
  logic m_busy;

  assign ld_stall = memtoRegE & regWriteE &
                    ((RA1D == WA3E) | (RA2D == WA3E));
  assign pc_acc   = pcWriteD & ~ld_stall & ~branchTakenE;

`ifdef HAZARD_MUL_STALL_EN
  localparam logic [2:0] MUL_LOAD = 3'(MUL_LAT - 2);

  logic [2:0] cnt_q, cnt_d;
  logic       mul_acc;

  assign mul_acc = mulStartE & ~branchTakenE;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_mul;

  assign unused_mul = mulStartE ^ (MUL_LAT == 0);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    s_f     = 1'b0;
    s_d     = 1'b0;
    s_e     = 1'b0;
    f_d     = 1'b0;
    f_e     = 1'b0;
    f_m     = 1'b0;
    m_busy  = 1'b0;
`ifdef HAZARD_MUL_STALL_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef HAZARD_MUL_STALL_EN
        if (mul_acc) begin
          s_f     = 1'b1;
          s_d     = 1'b1;
          s_e     = 1'b1;
          f_m     = 1'b1;
          m_busy  = 1'b1;
          cnt_d   = MUL_LOAD;
          state_d = MUL;
        end else
`endif
        begin
          s_f = ld_stall | pc_acc;
          s_d = ld_stall;
          f_e = ld_stall | branchTakenE;
          f_d = branchTakenE | pc_acc;
          if (pc_acc) state_d = PCW_E;
        end
      end
      PCW_E: begin
        s_f     = 1'b1;
        f_d     = 1'b1;
        state_d = PCW_M;
      end
      PCW_M: begin
        s_f     = 1'b1;
        f_d     = 1'b1;
        state_d = PCW_W;
      end
      PCW_W: begin
        f_d     = 1'b1;
        state_d = IDLE;
      end
`ifdef HAZARD_MUL_STALL_EN
      MUL: begin
        if (cnt_q != 3'd0) begin
          s_f    = 1'b1;
          s_d    = 1'b1;
          s_e    = 1'b1;
          f_m    = 1'b1;
          m_busy = 1'b1;
          cnt_d  = cnt_q - 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
`endif
    endcase
  end

  // Outputs are forced quiet for the whole reset interval.
  assign stallF   = reset_n & s_f;
  assign stallD   = reset_n & s_d;
  assign stallE   = reset_n & s_e;
  assign flushD   = reset_n & f_d;
  assign flushE   = reset_n & f_e;
  assign flushM   = reset_n & f_m;
  assign mulBusyE = reset_n & m_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Output vector order: stallF stallD stallE flushD flushE flushM mulBusyE.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] RA1D, RA2D, WA3E;
  logic       memtoRegE, regWriteE;
  logic       branchTakenE, pcWriteD, mulStartE;
  logic       stallF, stallD, stallE;
  logic       flushD, flushE, flushM, mulBusyE;
  logic [6:0] outs;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3E         (WA3E),
    .memtoRegE    (memtoRegE),
    .regWriteE    (regWriteE),
    .branchTakenE (branchTakenE),
    .pcWriteD     (pcWriteD),
    .mulStartE    (mulStartE),
    .stallF       (stallF),
    .stallD       (stallD),
    .stallE       (stallE),
    .flushD       (flushD),
    .flushE       (flushE),
    .flushM       (flushM),
    .mulBusyE     (mulBusyE)
  );

  always #5 clk = ~clk;

  assign outs = {stallF, stallD, stallE,
                 flushD, flushE, flushM, mulBusyE};

  // Apply one cycle of inputs at the falling edge.
  task automatic drive(input logic rn,
                       input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] wa, input logic mr,
                       input logic rw, input logic br,
                       input logic pw, input logic ms);
    @(negedge clk);
    reset_n = rn; RA1D = a1; RA2D = a2; WA3E = wa;
    memtoRegE = mr; regWriteE = rw;
    branchTakenE = br; pcWriteD = pw; mulStartE = ms;
    #1;
  endtask

  task automatic idle_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'd5, 4'd5, 4'd5, 1, 1, 1, 1, 1);
      n_cmp++;
      if (outs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d] got=%b exp=%b", i, outs, 7'b0);
      end
    end
    idle_cycle();
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", outs, 7'b0);
    end
  endtask

  task automatic test_load_use();
    drive(1, 4'd2, 4'd5, 4'd5, 1, 1, 0, 0, 0);
    n_cmp++;
    if (outs !== 7'b1100100) begin
      n_fail++;
      $display("FAIL ld_ra2 got=%b exp=%b", outs, 7'b1100100);
    end
    drive(1, 4'd2, 4'd5, 4'd0, 1, 1, 0, 0, 0);
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL ld_clear got=%b exp=%b", outs, 7'b0);
    end
    drive(1, 4'd7, 4'd1, 4'd7, 1, 1, 0, 0, 0);
    n_cmp++;
    if (outs !== 7'b1100100) begin
      n_fail++;
      $display("FAIL ld_ra1 got=%b exp=%b", outs, 7'b1100100);
    end
    drive(1, 4'd7, 4'd7, 4'd7, 0, 1, 0, 0, 0);
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL ld_not_load got=%b exp=%b", outs, 7'b0);
    end
    drive(1, 4'd7, 4'd7, 4'd7, 1, 0, 0, 0, 0);
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL ld_no_write got=%b exp=%b", outs, 7'b0);
    end
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    n_cmp++;
    if (outs !== 7'b0001100) begin
      n_fail++;
      $display("FAIL br_over_pcw got=%b exp=%b", outs, 7'b0001100);
    end
    idle_cycle();
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL br_stays_idle got=%b exp=%b", outs, 7'b0);
    end
  endtask

  task automatic test_pcw_seq();
    logic [6:0] exp [5];
    exp[0] = 7'b1001000; exp[1] = 7'b1001000;
    exp[2] = 7'b1001000; exp[3] = 7'b0001000;
    exp[4] = 7'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) idle_cycle();
      n_cmp++;
      if (outs !== exp[i]) begin
        n_fail++;
        $display("FAIL pcw_seq[%0d] got=%b exp=%b", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_ld_then_pcw();
    logic [6:0] exp [6];
    exp[0] = 7'b1100100; exp[1] = 7'b1001000;
    exp[2] = 7'b1001000; exp[3] = 7'b1001000;
    exp[4] = 7'b0001000; exp[5] = 7'b0;
    for (int i = 0; i < 6; i++) begin
      unique case (i)
        0: drive(1, 4'd3, 4'd0, 4'd3, 1, 1, 0, 1, 0);
        1: drive(1, 4'd3, 4'd0, 4'd9, 1, 1, 0, 1, 0);
        2, 3, 4: drive(1, 4'd3, 4'd3, 4'd3, 1, 1, 1, 1, 0);
        default: idle_cycle();
      endcase
      n_cmp++;
      if (outs !== exp[i]) begin
        n_fail++;
        $display("FAIL ld_pcw[%0d] got=%b exp=%b", i, outs, exp[i]);
      end
    end
  endtask

`ifdef HAZARD_MUL_STALL_EN
  task automatic test_mul();
    logic [6:0] exp [5];
    exp[0] = 7'b1110011; exp[1] = 7'b1110011;
    exp[2] = 7'b1110011; exp[3] = 7'b0;
    exp[4] = 7'b0;
    for (int i = 0; i < 5; i++) begin
      unique case (i)
        1: drive(1, 4'd1, 4'd1, 4'd1, 1, 1, 1, 1, 1);
        4: idle_cycle();
        default: drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
      endcase
      n_cmp++;
      if (outs !== exp[i]) begin
        n_fail++;
        $display("FAIL mul[%0d] got=%b exp=%b", i, outs, exp[i]);
      end
    end
    drive(1, 0, 0, 0, 0, 0, 1, 0, 1);
    n_cmp++;
    if (outs !== 7'b0001100) begin
      n_fail++;
      $display("FAIL mul_br_prio got=%b exp=%b", outs, 7'b0001100);
    end
    idle_cycle();
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL mul_br_after got=%b exp=%b", outs, 7'b0);
    end
  endtask
`else
  task automatic test_mul_disabled();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (outs !== 7'b0) begin
        n_fail++;
        $display("FAIL mul_off[%0d] got=%b exp=%b", i, outs, 7'b0);
      end
    end
    idle_cycle();
  endtask
`endif

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_cycle();
    idle_cycle();
    n_cmp++;
    if (outs !== 7'b1001000) begin
      n_fail++;
      $display("FAIL rst_mid_pre got=%b exp=%b", outs, 7'b1001000);
    end
    drive(0, 4'd4, 4'd4, 4'd4, 1, 1, 1, 1, 0);
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_mid_hold got=%b exp=%b", outs, 7'b0);
    end
    idle_cycle();
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_mid_idle got=%b exp=%b", outs, 7'b0);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (outs !== 7'b1001000) begin
      n_fail++;
      $display("FAIL rst_mid_resume got=%b exp=%b", outs, 7'b1001000);
    end
    repeat (4) idle_cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    RA1D = '0; RA2D = '0; WA3E = '0;
    memtoRegE = 1'b0; regWriteE = 1'b0;
    branchTakenE = 1'b0; pcWriteD = 1'b0; mulStartE = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_pcw_seq();
    test_ld_then_pcw();
`ifdef HAZARD_MUL_STALL_EN
    test_mul();
`else
    test_mul_disabled();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: MUL_LAT, 4, multiply occupancy of Execute in cycles; legal range 2..8.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: RA1D, RA2D  in  4 each  Decode source register addresses.
REQ-004 SHALL have ports:
- WA3E  in  4  Execute destination register.
- memtoRegE  in  1  Execute instruction is a load.
- regWriteE  in  1  Execute instruction writes a register.
REQ-005 SHALL have ports:
- branchTakenE  in  1  Execute branch resolved taken.
- pcWriteD  in  1  Decode instruction writes R15.
- mulStartE  in  1  Execute holds a multicycle multiply (level).
REQ-006 SHALL have outputs: stallF, stallD, stallE, flushD, flushE, flushM, mulBusyE; each 1 bit, active-high.

Function
REQ-007 SHALL compute ldrStall = memtoRegE & regWriteE & (RA1D==WA3E | RA2D==WA3E).
REQ-008 SHALL implement FSM states IDLE, PCW_E, PCW_M, PCW_W, MUL, plus a 3-bit down-counter cnt.
REQ-009 IDLE outputs SHALL be: stallF=stallD=ldrStall; flushE=ldrStall|branchTakenE; flushD=branchTakenE|pcAcc; stallF also asserted on pcAcc.
- pcAcc = pcWriteD & ~ldrStall & ~branchTakenE.
REQ-010 IDLE transition: branchTakenE -> stay IDLE; else mulAcc -> MUL; else pcAcc -> PCW_E; else stay IDLE.
- branchTakenE has priority over pcWriteD and mulStartE.
- mulAcc has priority over pcAcc.
- mulAcc = mulStartE & ~branchTakenE.
REQ-011 On mulAcc in IDLE, outputs SHALL be forced that same cycle:
- stallF=stallD=stallE=flushM=mulBusyE=1; flushD=flushE=0.
- cnt SHALL load MUL_LAT-2.
REQ-012 PCW_E, PCW_M SHALL assert stallF=1, flushD=1, all others 0, advancing PCW_E->PCW_M->PCW_W unconditionally.
REQ-013 PCW_W SHALL assert flushD=1 only (stallF=0 so redirected PC loads), then go to IDLE.
REQ-014 pcWriteD, ldrStall and branchTakenE SHALL be ignored in PCW_* states.
REQ-015 MUL with cnt!=0 SHALL assert stallF=stallD=stallE=flushM=mulBusyE=1 and decrement cnt.
REQ-016 MUL with cnt==0 SHALL assert no outputs, ignore mulStartE, and go to IDLE.
- Total stall = MUL_LAT-1 cycles; multiply occupies Execute MUL_LAT cycles.
REQ-017 ldrStall, branchTakenE and pcWriteD SHALL be ignored in MUL; flushE SHALL be 0 in MUL.
REQ-018 An instruction held by ldrStall SHALL be re-evaluated for pcAcc on the following cycle.
REQ-019 cnt SHALL never underflow; cnt SHALL be don't-care outside MUL but held at 0.

Reset
REQ-020 reset_n=0 at a rising edge SHALL set state=IDLE and cnt=0, regardless of current state, including mid-PCW or mid-MUL.
REQ-021 All outputs SHALL be 0 while reset_n=0, independent of other inputs.
REQ-022 Operation SHALL resume in IDLE on the first edge with reset_n=1; no outstanding PCW or MUL is resumed.

Configuration
REQ-023 Macro HAZARD_MUL_STALL_EN defined: MUL state, cnt, and multiply behaviour SHALL be present as specified.
REQ-024 Macro HAZARD_MUL_STALL_EN undefined:
- mulStartE SHALL be ignored.
- stallE, flushM, mulBusyE SHALL be tied 0.
- MUL state and cnt SHALL be absent.
- Port list SHALL be unchanged.

Verification
REQ-025 Bench SHALL cover:
- Load-use: memtoRegE=1, regWriteE=1, WA3E=5, RA2D=5 -> one cycle of stallF=stallD=flushE=1; next cycle with WA3E=0 -> all 0.
- Branch vs R15 write: branchTakenE=1 with pcWriteD=1 -> flushD=flushE=1; state stays IDLE.
- R15 write sequence: pcWriteD=1 in IDLE -> stallF/flushD =1,1 / 1,1 / 1,1 then stallF=0, flushD=1, then IDLE.
- Multiply, MUL_LAT=4: mulStartE held high -> stallE=1 for exactly 3 cycles, release on 4th cycle with mulStartE still high, no re-trigger.
- Reset mid-operation: reset_n=0 during PCW_M -> next cycle all outputs 0, state IDLE.
- Macro undefined: mulStartE=1 -> stallE=flushM=mulBusyE=0 for all cycles.
